// File: rtl/rvv_pkg.sv
// rtl/rvv_pkg.sv - shared opcodes, vtype layout, issue FSM states and VLMAX helper
package rvv_pkg;

    localparam logic [6:0] OP_V     = 7'b1010111;
    localparam logic [2:0] F3_OPCFG = 3'b111;

    typedef struct packed {
        logic       vill;
        logic [2:0] vsew;
        logic [2:0] vlmul;
    } vtype_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_CFG   = 2'd2
    } issue_state_e;

    localparam vtype_t VTYPE_RESET = '{vill: 1'b1, vsew: 3'd0, vlmul: 3'd0};

    // Reserved encodings (vlmul=4, vsew>3) return 0; callers flag them as vill.
    function automatic logic [31:0] vlmax_calc(input logic [31:0] vlen,
                                               input logic [2:0]  vsew,
                                               input logic [2:0]  vlmul);
        logic [31:0] base;
        base = vlen >> ({1'b0, vsew} + 4'd3);
        if (vsew > 3'd3) begin
            vlmax_calc = 32'd0;
        end else begin
            case (vlmul)
                3'd0:    vlmax_calc = base;
                3'd1:    vlmax_calc = base << 1;
                3'd2:    vlmax_calc = base << 2;
                3'd3:    vlmax_calc = base << 3;
                3'd5:    vlmax_calc = base >> 3;
                3'd6:    vlmax_calc = base >> 2;
                3'd7:    vlmax_calc = base >> 1;
                default: vlmax_calc = 32'd0;
            endcase
        end
    endfunction

endpackage

// File: rtl/rvv_instr_fifo.sv
// rtl/rvv_instr_fifo.sv - instruction queue holding {rs1, instr} entries
module rvv_instr_fifo
    import rvv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_tvalid,
    output logic        s_tready,
    input  logic [63:0] s_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic [63:0] m_tdata
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW:0]   count;
    logic          push;
    logic          pop;

    assign s_tready = (count != FULL_CNT);
    assign m_tvalid = (count != '0);
    assign m_tdata  = mem[head];
    assign pop      = m_tvalid && m_tready;
    // A pop frees the slot the same cycle, so a full queue may still take a write.
    assign push     = s_tvalid && (s_tready || pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= s_tdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= (tail == LAST_IDX) ? '0 : tail + 1'b1;
            end
            if (pop) begin
                head <= (head == LAST_IDX) ? '0 : head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rvv_vector_issue.sv
// rtl/rvv_vector_issue.sv - vector issue queue, vsetvli/vl unit and issue FSM; RVV_ISSUE_PERF_EN adds perf counters
module rvv_vector_issue
    import rvv_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int VLEN  = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_rs1,
    output logic        in_ready,
    output logic        vec_valid,
    output logic [31:0] vec_instr,
    output logic [31:0] vec_vl,
    input  logic        vec_ready,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic        illegal
`ifdef RVV_ISSUE_PERF_EN
    ,
    output logic [31:0] perf_issued,
    output logic [31:0] perf_stall
`endif
);

    issue_state_e state;
    issue_state_e state_nxt;
    vtype_t       vtype;
    vtype_t       cfg_vtype;
    logic [31:0]  vl;
    logic [31:0]  cfg_vl;
    logic [31:0]  cfg_vlmax;
    logic [2:0]   cfg_vsew;
    logic [2:0]   cfg_vlmul;
    logic         cfg_bad;
    logic         q_valid;
    logic         q_pop;
    logic [63:0]  q_data;
    logic [31:0]  head_instr;
    logic [31:0]  head_rs1;
    logic         head_is_v;
    logic         head_is_cfg;
    logic         head_drop;
    logic         drop_now;
    logic         vtype_unused;

    rvv_instr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .s_tvalid (in_valid && in_ready),
        .s_tready (in_ready),
        .s_tdata  ({in_rs1, in_instr}),
        .m_tvalid (q_valid),
        .m_tready (q_pop),
        .m_tdata  (q_data)
    );

    assign head_instr  = q_data[31:0];
    assign head_rs1    = q_data[63:32];
    assign head_is_v   = (head_instr[6:0] == OP_V);
    assign head_is_cfg = head_is_v && (head_instr[14:12] == F3_OPCFG) && !head_instr[31];
    assign head_drop   = !head_is_v || vtype.vill;

    // vsew/vlmul are architectural state kept for the vector unit; only vill steers issue here.
    assign vtype_unused = ^{vtype.vsew, vtype.vlmul};

    assign cfg_vsew  = head_instr[25:23];
    assign cfg_vlmul = head_instr[22:20];
    assign cfg_bad   = (cfg_vlmul == 3'd4) || (cfg_vsew > 3'd3);
    assign cfg_vlmax = vlmax_calc(32'(VLEN), cfg_vsew, cfg_vlmul);
    assign cfg_vtype = cfg_bad ? VTYPE_RESET : '{vill: 1'b0, vsew: cfg_vsew, vlmul: cfg_vlmul};

    // rs1 field picks the AVL source; rs1=x0,rd=x0 leaves vl untouched.
    always_comb begin
        cfg_vl = vl;
        if (cfg_bad) begin
            cfg_vl = '0;
        end else if (head_instr[19:15] != 5'd0) begin
            cfg_vl = (head_rs1 < cfg_vlmax) ? head_rs1 : cfg_vlmax;
        end else if (head_instr[11:7] != 5'd0) begin
            cfg_vl = cfg_vlmax;
        end
    end

    always_comb begin
        state_nxt = state;
        q_pop     = 1'b0;
        drop_now  = 1'b0;
        case (state)
            S_IDLE: begin
                if (q_valid) begin
                    if (head_is_cfg) begin
                        state_nxt = S_CFG;
                    end else if (head_drop) begin
                        q_pop    = 1'b1;
                        drop_now = 1'b1;
                    end else begin
                        state_nxt = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (vec_ready) begin
                    q_pop     = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_CFG: begin
                q_pop     = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign vec_valid = (state == S_ISSUE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            vtype     <= VTYPE_RESET;
            vl        <= '0;
            vec_instr <= '0;
            vec_vl    <= '0;
            wb_valid  <= 1'b0;
            wb_data   <= '0;
            illegal   <= 1'b0;
        end else begin
            state    <= state_nxt;
            wb_valid <= (state == S_CFG);
            illegal  <= drop_now;
            if ((state == S_IDLE) && (state_nxt == S_ISSUE)) begin
                vec_instr <= head_instr;
                vec_vl    <= vl;
            end
            if (state == S_CFG) begin
                vtype   <= cfg_vtype;
                vl      <= cfg_vl;
                wb_data <= cfg_vl;
            end
        end
    end

`ifdef RVV_ISSUE_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (vec_valid && vec_ready) begin
                perf_issued <= perf_issued + 32'd1;
            end
            if (vec_valid && !vec_ready) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule
